// File: rtl/pixel_proc_pkg.sv
// pixel_proc_pkg: op codes and grayscale weights shared by the pixel stream processor
package pixel_proc_pkg;
  typedef enum logic [1:0] {
    OP_INVERT = 2'b00,
    OP_THRESH = 2'b01,
    OP_BRIGHT = 2'b10,
    OP_GRAY   = 2'b11
  } op_e;
  localparam logic [7:0] GRAY_WR = 8'd77;
  localparam logic [7:0] GRAY_WG = 8'd150;
  localparam logic [7:0] GRAY_WB = 8'd29;
  localparam int GRAY_SHIFT = 8;
endpackage

// File: rtl/pixel_op_alu.sv
// pixel_op_alu: combinational single-pixel point operation (invert/threshold/brightness/grayscale)
module pixel_op_alu import pixel_proc_pkg::*; #(
  parameter int CH_W = 8
) (
  input  logic [1:0]        i_op,
  input  logic [CH_W-1:0]   i_thresh,
  input  logic [CH_W-1:0]   i_bright,
  input  logic [3*CH_W-1:0] i_pix,
  output logic [3*CH_W-1:0] o_pix
);
  localparam int GW = CH_W + 8;
  logic [GW-1:0]   w_gsum;
  logic [CH_W-1:0] w_gray;
  assign w_gsum = GW'(i_pix[2*CH_W +: CH_W]) * GW'(GRAY_WR)
                + GW'(i_pix[CH_W +: CH_W]) * GW'(GRAY_WG)
                + GW'(i_pix[0 +: CH_W]) * GW'(GRAY_WB);
  assign w_gray = CH_W'(w_gsum >> GRAY_SHIFT);
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [CH_W-1:0] w_c;
    logic [CH_W+1:0] w_sum;
    assign w_c   = i_pix[i*CH_W +: CH_W];
    // two guard bits: top bit flags underflow, next one flags overflow
    assign w_sum = {2'b00, w_c} + {{2{i_bright[CH_W-1]}}, i_bright};
    assign o_pix[i*CH_W +: CH_W] =
      (i_op == OP_INVERT) ? ~w_c :
      (i_op == OP_THRESH) ? ((w_c > i_thresh) ? '1 : '0) :
      (i_op == OP_BRIGHT) ? (w_sum[CH_W+1] ? '0 : w_sum[CH_W] ? '1 : w_sum[CH_W-1:0]) :
      w_gray;
  end
endmodule

// File: rtl/pixel_stream_processor.sv
// pixel_stream_processor: 2-stage valid/ready RGB point-op pipeline with frame position markers
module pixel_stream_processor import pixel_proc_pkg::*; #(
  parameter int CH_W  = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_op,
  input  logic [CH_W-1:0]   cfg_thresh,
  input  logic [CH_W-1:0]   cfg_bright,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [3*CH_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3*CH_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              frame_done,
  output logic              busy
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [1:0]        r_op;
  logic [CH_W-1:0]   r_thresh, r_bright;
  logic              r_v1, r_sof1, r_eol1, r_eof1;
  logic [3*CH_W-1:0] r_d1, w_alu;
  logic              w_adv, w_in, w_out_eof, w_first, w_last_x, w_last_y;
  assign w_adv     = !m_valid || m_ready;
  assign s_ready   = !rst && w_adv;
  assign w_in      = s_valid && s_ready;
  assign w_out_eof = m_valid && m_ready && m_eof;
  assign w_first   = r_x == '0 && r_y == '0;
  assign w_last_x  = r_x == XW'(IMG_W - 1);
  assign w_last_y  = r_y == YW'(IMG_H - 1);
  // shadow config loads on the same edge the (0,0) pixel enters stage 1, so it
  // takes effect exactly as the last pixel of the previous frame leaves the ALU
  pixel_op_alu #(.CH_W(CH_W)) u_alu (
    .i_op(r_op), .i_thresh(r_thresh), .i_bright(r_bright), .i_pix(r_d1), .o_pix(w_alu)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
      r_op <= OP_INVERT;
      r_thresh <= '0;
      r_bright <= '0;
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_sof1 <= 1'b0;
      r_eol1 <= 1'b0;
      r_eof1 <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sof <= 1'b0;
      m_eol <= 1'b0;
      m_eof <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (w_in) begin
        r_x <= w_last_x ? '0 : r_x + 1'b1;
        if (w_last_x) r_y <= w_last_y ? '0 : r_y + 1'b1;
        if (w_first) begin
          r_op <= cfg_op;
          r_thresh <= cfg_thresh;
          r_bright <= cfg_bright;
        end
      end
      if (w_adv) begin
        r_v1 <= s_valid;
        r_d1 <= s_data;
        r_sof1 <= w_first;
        r_eol1 <= w_last_x;
        r_eof1 <= w_last_x && w_last_y;
        m_valid <= r_v1;
        m_data <= w_alu;
        m_sof <= r_v1 && r_sof1;
        m_eol <= r_v1 && r_eol1;
        m_eof <= r_v1 && r_eof1;
      end
      frame_done <= w_out_eof;
      busy <= w_in || (busy && !w_out_eof);
    end
  end
endmodule

// File: tb/tb_pixel_stream_processor.sv
// tb_pixel_stream_processor: directed table vectors plus randomized frames against a scoreboard model
module tb_pixel_stream_processor;
  import pixel_proc_pkg::*;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int NPIX = IW * IH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cfg_op = 2'b00;
  logic [7:0] cfg_thresh = 8'h00;
  logic [7:0] cfg_bright = 8'h00;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [23:0] s_data = 24'h0;
  logic m_valid;
  logic m_ready = 1'b1;
  logic [23:0] m_data;
  logic m_sof, m_eol, m_eof, frame_done, busy;
  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  bit rnd_rdy = 1'b0;
  typedef struct {
    logic [23:0] d;
    logic sof, eol, eof;
  } exp_t;
  typedef struct {
    logic [1:0] op;
    logic [7:0] th;
    logic [7:0] br;
    logic [23:0] din;
    logic [23:0] dout;
  } vec_t;
  exp_t q[$];
  pixel_stream_processor #(.CH_W(8), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .cfg_op(cfg_op), .cfg_thresh(cfg_thresh), .cfg_bright(cfg_bright),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1 m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] model(input logic [1:0] op, input logic [7:0] th,
                                         input logic [7:0] br, input logic [23:0] p);
    int c[3];
    int o[3];
    int g;
    c[0] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[2] = int'(p[7:0]);
    g = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
    for (int i = 0; i < 3; i++) begin
      case (op)
        2'b00: o[i] = 255 - c[i];
        2'b01: o[i] = (c[i] > int'(th)) ? 255 : 0;
        2'b10: begin
          o[i] = c[i] + int'($signed(br));
          if (o[i] < 0) o[i] = 0;
          if (o[i] > 255) o[i] = 255;
        end
        default: o[i] = g;
      endcase
    end
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction
  int pos = 0;
  logic [1:0] f_op;
  logic [7:0] f_th, f_br;
  bit fd_exp = 1'b0;
  bit busy_exp = 1'b0;
  // scoreboard: sampled mid-cycle, so valid&ready here means a transfer on the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      pos = 0;
      fd_exp = 1'b0;
      busy_exp = 1'b0;
    end else begin
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      chk("busy", 64'(busy), 64'(busy_exp));
      if (frame_done) fd_cnt++;
      fd_exp = m_valid && m_ready && m_eof;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_pixel: got %h with nothing expected at %0t", m_data, $time);
        end else begin
          e = q.pop_front();
          chk("pixel", {37'd0, m_data, m_sof, m_eol, m_eof}, {37'd0, e.d, e.sof, e.eol, e.eof});
        end
      end
      if (s_valid && s_ready) begin
        if (pos == 0) begin
          f_op = cfg_op;
          f_th = cfg_thresh;
          f_br = cfg_bright;
        end
        e.d = model(f_op, f_th, f_br, s_data);
        e.sof = pos == 0;
        e.eol = (pos % IW) == IW - 1;
        e.eof = pos == NPIX - 1;
        q.push_back(e);
        pos = (pos + 1) % NPIX;
      end
      busy_exp = (s_valid && s_ready) ? 1'b1 : (m_valid && m_ready && m_eof) ? 1'b0 : busy_exp;
    end
  end
  task automatic send(input logic [23:0] p);
    int t;
    s_valid = 1'b1;
    s_data = p;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: s_ready stuck at %b expected 1", s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || m_valid) && t < 400) begin
      @(posedge clk);
      #1 t++;
    end
    n_cmp++;
    if (q.size() != 0 || m_valid) begin
      n_err++;
      $display("FAIL drain: %0d pixels outstanding, expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic rand_cfg();
    cfg_op = 2'($urandom);
    cfg_thresh = 8'($urandom);
    cfg_bright = 8'($urandom);
  endtask
  vec_t tv[7];
  initial begin
    int fd0;
    tv[0] = '{OP_INVERT, 8'h00, 8'h00, 24'h123456, 24'hEDCBA9};
    tv[1] = '{OP_THRESH, 8'h80, 8'h00, 24'h80817F, 24'h00FF00};
    tv[2] = '{OP_BRIGHT, 8'h00, 8'h20, 24'hF01000, 24'hFF3020};
    tv[3] = '{OP_BRIGHT, 8'h00, 8'hE0, 24'h10FF40, 24'h00DF20};
    tv[4] = '{OP_GRAY,   8'h00, 8'h00, 24'hFFFFFF, 24'hFFFFFF};
    tv[5] = '{OP_GRAY,   8'h00, 8'h00, 24'h804020, 24'h4F4F4F};
    tv[6] = '{OP_THRESH, 8'h00, 8'h00, 24'h000001, 24'h0000FF};
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {33'd0, m_valid, m_data, m_sof, m_eol, m_eof, frame_done, busy, s_ready}, 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      cfg_op = tv[i].op;
      cfg_thresh = tv[i].th;
      cfg_bright = tv[i].br;
      s_valid = 1'b1;
      s_data = tv[i].din;
      @(posedge clk);
      #1 s_valid = 1'b0;
      rand_cfg();
      chk("latency_1clk_empty", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1 chk("vector_out", {39'd0, m_valid, m_sof, m_data}, {39'd0, 1'b1, 1'b1, tv[i].dout});
      for (int k = 1; k < NPIX; k++) send(24'($urandom));
      drain();
    end
    rnd_rdy = 1'b1;
    fd0 = fd_cnt;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NPIX; k++) begin
        if ((k == 0 && f % 2 == 0) || k == 3) rand_cfg();
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(24'($urandom));
      end
    end
    drain();
    chk("frame_done_count", 64'(fd_cnt - fd0), 64'd6);
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NPIX; k++) begin
      s_valid = 1'b1;
      s_data = 24'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    drain();
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) send(24'($urandom));
    #2 rst = 1'b1;
    #1 chk("async_reset", {33'd0, m_valid, m_data, m_sof, m_eol, m_eof, frame_done, busy, s_ready}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rand_cfg();
    for (int k = 0; k < NPIX; k++) send(24'($urandom));
    drain();
    chk("frame_done_after_reset", 64'(fd_cnt - fd0), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
